alu_result_stage: RTL

Registered output stage of the ALU. Each cycle it takes the parallel results of the adder, boolean unit, shifter and compare unit and selects one with ALUFN[5:4]. It latches the selected result and the adder flags into a two-entry skid buffer and presents them downstream on a valid/ready handshake. It breaks the combinational path from the ALU units to writeback, so a downstream stall never drops or duplicates a result.

---
 rtl/alu_result_stage_pkg.sv | 29 ++
 rtl/alu_result_mux.sv | 43 ++++
 rtl/alu_result_stage.sv | 112 +++++++++++
 3 files changed

// File: rtl/alu_result_stage_pkg.sv
// Shared ALU definitions: unit-select codes, result-entry field layout and
// the occupancy encoding used by the registered result stage.
package alu_result_stage_pkg;

    localparam logic [1:0] UNIT_ADD   = 2'b00;
    localparam logic [1:0] UNIT_BOOL  = 2'b01;
    localparam logic [1:0] UNIT_SHIFT = 2'b10;
    localparam logic [1:0] UNIT_CMP   = 2'b11;

    // Entry = {res, z, v, n, unit}; total width is WIDTH + ENTRY_META_W.
    localparam int ENTRY_META_W = 5;
    localparam int UNIT_LSB     = 0;
    localparam int N_BIT        = 2;
    localparam int V_BIT        = 3;
    localparam int Z_BIT        = 4;
    localparam int RES_LSB      = 5;

    // Encoded as {main_v, skid_v}; 2'b01 is never legal.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b10,
        ST_FULL  = 2'b11
    } state_t;

    function automatic int entry_width(input int width);
        return width + ENTRY_META_W;
    endfunction

endpackage

// File: rtl/alu_result_mux.sv
// Combinational unit-result select with zero/overflow/negative flag formation.
// Packs the outcome into one result entry; usable without the register stage.
module alu_result_mux
    import alu_result_stage_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [1:0]                      unit_i,
    input  logic [WIDTH-1:0]                add_res_i,
    input  logic [WIDTH-1:0]                bool_res_i,
    input  logic [WIDTH-1:0]                shift_res_i,
    input  logic [WIDTH-1:0]                cmp_res_i,
    input  logic                            add_v_i,
    input  logic                            add_n_i,
    output logic [WIDTH+ENTRY_META_W-1:0]   entry_o
);

    logic [WIDTH-1:0] res;
    logic             is_add;

    always_comb begin
        res = add_res_i;
        case (unit_i)
            UNIT_BOOL:  res = bool_res_i;
            UNIT_SHIFT: res = shift_res_i;
            UNIT_CMP:   res = cmp_res_i;
            default:    res = add_res_i;
        endcase
    end

    assign is_add = (unit_i == UNIT_ADD);

    // Adder flags are meaningless for other units, so they are cleared here.
    always_comb begin
        entry_o                     = '0;
        entry_o[RES_LSB +: WIDTH]   = res;
        entry_o[Z_BIT]              = (res == '0);
        entry_o[V_BIT]              = is_add & add_v_i;
        entry_o[N_BIT]              = is_add & add_n_i;
        entry_o[UNIT_LSB +: 2]      = unit_i;
    end

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU output stage: selects one unit result and holds it in a
// two-entry skid buffer behind a valid/ready handshake toward writeback.
module alu_result_stage
    import alu_result_stage_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        alufn,
    input  logic [WIDTH-1:0]  add_res,
    input  logic [WIDTH-1:0]  bool_res,
    input  logic [WIDTH-1:0]  shift_res,
    input  logic [WIDTH-1:0]  cmp_res,
    input  logic              add_v,
    input  logic              add_n,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_res,
    output logic              out_z,
    output logic              out_v,
    output logic              out_n,
    output logic [1:0]        out_unit
);

    localparam int EW = entry_width(WIDTH);

    // Handshake: a transfer happens on a rising edge where valid && ready;
    // the sender holds its payload stable until then, ready never waits on valid.
    state_t          state_q, state_d;
    logic [EW-1:0]   main_q, main_d;
    logic [EW-1:0]   skid_q, skid_d;
    logic [EW-1:0]   mux_entry;
    logic            accept, drain;
    logic            unused_alufn_lo;

    assign unused_alufn_lo = ^alufn[3:0];

    alu_result_mux #(.WIDTH(WIDTH)) u_mux (
        .unit_i      (alufn[5:4]),
        .add_res_i   (add_res),
        .bool_res_i  (bool_res),
        .shift_res_i (shift_res),
        .cmp_res_i   (cmp_res),
        .add_v_i     (add_v),
        .add_n_i     (add_n),
        .entry_o     (mux_entry)
    );

    assign accept = in_valid & in_ready;
    assign drain  = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    main_d  = mux_entry;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && drain) begin
                    main_d = mux_entry;
                end else if (accept) begin
                    skid_d  = mux_entry;
                    state_d = ST_FULL;
                end else if (drain) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (drain) begin
                    main_d  = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // All outputs derive from registers only, so no input-to-output path exists.
    always_comb begin
        in_ready  = (state_q != ST_FULL);
        out_valid = (state_q == ST_ONE) || (state_q == ST_FULL);
        out_res   = main_q[RES_LSB +: WIDTH];
        out_z     = main_q[Z_BIT];
        out_v     = main_q[V_BIT];
        out_n     = main_q[N_BIT];
        out_unit  = main_q[UNIT_LSB +: 2];
    end

    a_no_skid_without_main: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == ST_EMPTY) || (state_q == ST_ONE) || (state_q == ST_FULL));

endmodule
